timer_ctrl: RTL and testbench

Controller that sequences a WIDTH-bit up-counter datapath as a programmable interval timer.
- Latches a period, runs the counter from 0 to that period and flags terminal count.
- Supports pause/resume, one-shot or auto-reload operation, and synchronous clear.
- Sits between a control register interface and downstream logic that consumes the terminal-count pulse.

---
 rtl/timer_pkg.sv | 5 +
 rtl/timer_count.sv | 19 +
 rtl/timer_ctrl.sv | 70 +++++++
 tb/tb_timer_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and default width for the interval timer.
package timer_pkg;
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
   localparam int WIDTH_DEF = 4;
endpackage

// File: rtl/timer_count.sv
// timer_count: registered up-counter with synchronous clear (clr beats en).
module timer_count
   import timer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] sum;
   assign sum = q + 1'b1;
   always_ff @(posedge clk or negedge rst)
      if (!rst) q <= '0;
      else if (clr) q <= '0;
      else if (en) q <= sum;
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable interval timer controller (one-shot / auto-reload, pause, clear).
// Optional prescaler enabled by defining TIMER_CTRL_PRESCALE_EN.
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
`ifdef TIMER_CTRL_PRESCALE_EN
   , parameter int PRESCALE = 4
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tick,
   output logic             done
);
   state_t state_q, state_d;
   logic [WIDTH-1:0] period_q;
   logic reload_q, advance, load, hit, cnt_clr, cnt_en;
   assign hit  = count == period_q;
   assign load = !clear && start && (state_q == IDLE || state_q == DONE);
   // stop beats the reload clear so a paused timer keeps its terminal count
   assign cnt_clr = clear || load || (tick && reload_q && !stop);
   assign cnt_en  = state_q == RUN && !stop && advance && !hit;
`ifdef TIMER_CTRL_PRESCALE_EN
   localparam int PW = $clog2(PRESCALE);
   logic [PW-1:0] psc_q;
   assign advance = psc_q == PW'(PRESCALE - 1);
   always_ff @(posedge clk or negedge rst)
      if (!rst) psc_q <= '0;
      else if (clear || load) psc_q <= '0;
      else if (state_q == RUN && !stop) psc_q <= advance ? '0 : psc_q + 1'b1;
`else
   assign advance = 1'b1;
`endif
   always_ff @(posedge clk or negedge rst)
      if (!rst) state_q <= IDLE;
      else state_q <= state_d;
   always_comb
      state_d = clear             ? IDLE :
                state_q == RUN    ? (stop ? PAUSE : (tick && !reload_q) ? DONE : RUN) :
                state_q == PAUSE  ? ((start && !stop) ? RUN : PAUSE) :
                start             ? RUN : state_q;
   always_comb begin
      busy = state_q == RUN || state_q == PAUSE;
      done = state_q == DONE;
      tick = state_q == RUN && hit && advance;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         period_q <= '0;
         reload_q <= 1'b0;
      end else if (load) begin
         period_q <= period;
         reload_q <= auto_reload;
      end
   timer_count #(.WIDTH(WIDTH)) u_count (
      .clk(clk),
      .rst(rst),
      .en (cnt_en),
      .clr(cnt_clr),
      .q  (count)
   );
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed self-checking bench for timer_ctrl.
module tb_timer_ctrl;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, auto_reload = 1'b0;
   logic [3:0] period = '0;
   logic [3:0] count;
   logic busy, tick, done;
   int checks = 0, errors = 0, ticks;

   timer_ctrl #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
      .auto_reload(auto_reload), .period(period),
      .count(count), .busy(busy), .tick(tick), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic st(input string tag, input logic [3:0] c, input logic b, input logic t, input logic d);
      chk({tag, ".count"}, 32'(c), 32'(count));
      chk({tag, ".busy"}, 32'(b), 32'(busy));
      chk({tag, ".tick"}, 32'(t), 32'(tick));
      chk({tag, ".done"}, 32'(d), 32'(done));
   endtask

   initial begin
      #3;
      st("reset", 4'd0, 1'b0, 1'b0, 1'b0);
      step();
      rst = 1'b1;
`ifdef TIMER_CTRL_PRESCALE_EN
      period = 4'd1; auto_reload = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      ticks = 0;
      for (int i = 0; i < 16; i++) begin
         chk("psc.count", 32'(count), 32'((i / 4) % 2));
         chk("psc.tick", 32'(tick), 32'(i % 8 == 7));
         ticks += int'(tick);
         step();
      end
      chk("psc.ticks", 32'(ticks), 32'd2);
`else
      // one-shot, period 3
      period = 4'd3; auto_reload = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      st("os0", 4'd0, 1'b1, 1'b0, 1'b0);
      step(); st("os1", 4'd1, 1'b1, 1'b0, 1'b0);
      step(); st("os2", 4'd2, 1'b1, 1'b0, 1'b0);
      step(); st("os3", 4'd3, 1'b1, 1'b1, 1'b0);
      step(); st("osdone", 4'd3, 1'b0, 1'b0, 1'b1);
      step(); st("oshold", 4'd3, 1'b0, 1'b0, 1'b1);
      // auto-reload, period 2, restart from DONE; mid-run period change ignored
      period = 4'd2; auto_reload = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      ticks = 0;
      for (int i = 0; i < 9; i++) begin
         if (i == 4) period = 4'd7;
         st("ar", 4'(i % 3), 1'b1, 1'(i % 3 == 2), 1'b0);
         ticks += int'(tick);
         step();
      end
      chk("ar.ticks", 32'(ticks), 32'd3);
      clear = 1'b1;
      step();
      clear = 1'b0;
      st("clr", 4'd0, 1'b0, 1'b0, 1'b0);
      // pause / resume, period 5
      period = 4'd5; auto_reload = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      st("pr2", 4'd2, 1'b1, 1'b0, 1'b0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      for (int i = 0; i < 4; i++) begin
         st("paused", 4'd2, 1'b1, 1'b0, 1'b0);
         step();
      end
      start = 1'b1;
      step();
      start = 1'b0;
      st("resume", 4'd2, 1'b1, 1'b0, 1'b0);
      step(); st("pr3", 4'd3, 1'b1, 1'b0, 1'b0);
      step(); st("pr4", 4'd4, 1'b1, 1'b0, 1'b0);
      step(); st("pr5", 4'd5, 1'b1, 1'b1, 1'b0);
      step(); st("prdone", 4'd5, 1'b0, 1'b0, 1'b1);
      // start+stop in RUN pauses; clear from PAUSE
      period = 4'd4; auto_reload = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      step();
      start = 1'b1; stop = 1'b1;
      step();
      st("ss", 4'd1, 1'b1, 1'b0, 1'b0);
      step();
      start = 1'b0; stop = 1'b0;
      st("sspause", 4'd1, 1'b1, 1'b0, 1'b0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      st("pclr", 4'd0, 1'b0, 1'b0, 1'b0);
      // asynchronous reset mid-run
      period = 4'd6; start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      st("prerst", 4'd2, 1'b1, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1 st("arst", 4'd0, 1'b0, 1'b0, 1'b0);
      step();
      rst = 1'b1;
      // period 0 auto-reload: continuous tick
      period = 4'd0; auto_reload = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         st("p0ar", 4'd0, 1'b1, 1'b1, 1'b0);
         step();
      end
      clear = 1'b1;
      step();
      clear = 1'b0;
      // period 0 one-shot
      auto_reload = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      st("p0os", 4'd0, 1'b1, 1'b1, 1'b0);
      step(); st("p0done", 4'd0, 1'b0, 1'b0, 1'b1);
      // restart from DONE with new period 1, auto-reload
      period = 4'd1; auto_reload = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         st("p1ar", 4'(i % 2), 1'b1, 1'(i % 2), 1'b0);
         step();
      end
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
